// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-manager port between instruction fetch
// (read-only) and the data path (read/write).
//
// Flow: IDLE (arbitrate) -> ISSUE (strobe) -> WAIT (handshake + watchdog)
//       -> DONE (one-cycle done pulse) -> IDLE.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   f_req/f_addr                 fetch request (level) and address
//   f_rdata/f_done               fetch read data (held) and done pulse
//   d_req/d_addr/d_wdata/d_rnw   data request, address, write data, direction
//   d_rdata/d_done               data read data (held) and done pulse
//   bus_err                      accompanies done when the access timed out
//   mem_addr/mem_wdata/mem_rnw   registered access to the memory manager
//   mem_enable                   access strobe, high through ISSUE and WAIT
//   mem_rdata/mem_ready          memory manager response
module mem_arbiter #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_done,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_rnw,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          bus_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rnw,
  output logic          mem_enable,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          owner_d;  // 1 = current access belongs to the data path
  logic          last_d;   // 1 = data path was served last
  logic [CW-1:0] cnt;
  logic          grant_d;
  logic          expire;

  // Data wins when it is the only requester, or on a tie when fetch was
  // served last.
  assign grant_d = d_req && (!f_req || !last_d);
  assign expire  = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      last_d     <= 1'b1;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rnw    <= 1'b1;
      mem_enable <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Completion flags only live for the single DONE cycle.
      f_done  <= 1'b0;
      d_done  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (f_req || d_req) begin
            owner_d    <= grant_d;
            last_d     <= grant_d;
            mem_addr   <= grant_d ? d_addr : f_addr;
            mem_wdata  <= d_wdata;
            mem_rnw    <= grant_d ? d_rnw : 1'b1;
            mem_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Ready takes priority over a watchdog expiry on the same edge.
          if (mem_ready || expire) begin
            if (!mem_ready) begin
              bus_err <= 1'b1;
              if (owner_d) d_rdata <= '1;
              else         f_rdata <= '1;
            end else if (mem_rnw) begin
              if (owner_d) d_rdata <= mem_rdata;
              else         f_rdata <= mem_rdata;
            end
            f_done     <= !owner_d;
            d_done     <= owner_d;
            mem_enable <= 1'b0;
            cnt        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural memory responder raises
// mem_ready on a chosen WAIT cycle (random noise elsewhere, which the design
// must ignore); a transaction-level model predicts owner, latency, error and
// read-data for each access.
module tb_mem_arbiter;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       f_req, d_req, d_rnw;
  logic [7:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  logic       f_done, d_done, bus_err, mem_rnw, mem_enable, mem_ready;

  mem_arbiter #(.DW(8), .AW(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_rnw(d_rnw),
    .d_rdata(d_rdata), .d_done(d_done), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rnw(mem_rnw),
    .mem_enable(mem_enable), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory responder: en_cyc counts enable cycles already elapsed, so the
  // ISSUE cycle sees 0 and the k-th WAIT cycle sees k.
  int   ready_at;
  int   en_cyc;
  logic noise;
  always @(posedge clk or posedge rst)
    if (rst) en_cyc <= 0;
    else     en_cyc <= mem_enable ? en_cyc + 1 : 0;
  always @(negedge clk) noise <= 1'($urandom_range(0, 1));
  assign mem_ready = (mem_enable && en_cyc != 0) ? (en_cyc == ready_at) : noise;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         ptr_d;
  logic [7:0] m_f, m_d;
  bit         ed, ee;
  int         el;

  // Observations from one access
  int         lat;
  bit         who, unst, err, both, tmo;
  logic [7:0] oa, ow, ofr, odr;
  logic       orr;

  task automatic model_reset();
    ptr_d = 1'b1; m_f = '0; m_d = '0;
  endtask

  // Transaction-level prediction of one access.
  task automatic model(input bit fr, input bit dr, input bit rnw, input int rdy,
                       input logic [7:0] rdv);
    if (fr && dr) ed = !ptr_d;
    else          ed = dr;
    ptr_d = ed;
    ee = (rdy > TO);
    el = 2 + (ee ? TO : rdy);
    if (ee) begin
      if (ed) m_d = 8'hFF; else m_f = 8'hFF;
    end else if (!ed) m_f = rdv;
    else if (rnw)     m_d = rdv;
  endtask

  task automatic drive(input bit fr, input bit dr, input logic [7:0] fa,
                       input logic [7:0] da, input logic [7:0] dw, input bit rnw,
                       input int rdy, input logic [7:0] rdv);
    f_req = fr; d_req = dr; f_addr = fa; d_addr = da; d_wdata = dw;
    d_rnw = rnw; ready_at = rdy; mem_rdata = rdv;
  endtask

  // Follows one access until a done pulse (bounded), recording what was seen.
  task automatic serve();
    bit first = 1'b1;
    bit fin = 1'b0;
    lat = 0; unst = 0; both = 0; tmo = 0; who = 0; err = 0;
    oa = '0; ow = '0; orr = 1'b0; ofr = '0; odr = '0;
    while (!fin) begin
      @(negedge clk); lat++;
      if (mem_enable) begin
        if (first) begin oa = mem_addr; ow = mem_wdata; orr = mem_rnw; first = 0; end
        else if (mem_addr !== oa || mem_wdata !== ow || mem_rnw !== orr) unst = 1;
      end
      if (f_done && d_done) both = 1;
      if (f_done || d_done) begin
        who = d_done; err = bus_err; ofr = f_rdata; odr = d_rdata; fin = 1;
      end else if (lat > 60) begin
        tmo = 1; fin = 1;
      end
    end
  endtask

  task automatic finish_access();
    f_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; #1;
    checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b exp 0", mem_enable); end
    checks++; if (mem_rnw !== 1'b1) begin errors++; $display("FAIL reset_rnw: got %b exp 1", mem_rnw); end
    checks++; if ({f_done, d_done, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {f_done, d_done, bus_err}); end
    checks++; if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", {mem_addr, mem_wdata, f_rdata, d_rdata}); end
    @(negedge clk); rst = 0; model_reset();
    @(negedge clk);
  endtask

  task automatic test_fetch();
    drive(1, 0, 8'h10, 8'h00, 8'h00, 1, 1, 8'hA5);
    model(1, 0, 1, 1, 8'hA5);
    serve();
    checks++; if (tmo) begin errors++; $display("FAIL fetch_hang: no done within bound"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL fetch_latency: got %0d exp 3", lat); end
    checks++; if (who !== 1'b0) begin errors++; $display("FAIL fetch_owner: got d=%b exp d=0", who); end
    checks++; if (oa !== 8'h10 || orr !== 1'b1) begin errors++; $display("FAIL fetch_bus: got addr=%h rnw=%b exp 10/1", oa, orr); end
    checks++; if (ofr !== 8'hA5 || err !== 1'b0) begin errors++; $display("FAIL fetch_data: got %h err=%b exp a5 err=0", ofr, err); end
    finish_access();
    checks++; if (f_done !== 1'b0 || f_rdata !== 8'hA5) begin errors++; $display("FAIL fetch_pulse: got done=%b rdata=%h exp 0/a5", f_done, f_rdata); end
  endtask

  task automatic test_write();
    drive(0, 1, 8'h00, 8'h20, 8'h3C, 0, 3, 8'hEE);
    model(0, 1, 0, 3, 8'hEE);
    serve();
    checks++; if (tmo) begin errors++; $display("FAIL write_hang: no done within bound"); end
    checks++; if (lat != el) begin errors++; $display("FAIL write_latency: got %0d exp %0d", lat, el); end
    checks++; if (who !== 1'b1 || oa !== 8'h20 || ow !== 8'h3C || orr !== 1'b0) begin errors++; $display("FAIL write_bus: got d=%b addr=%h wdata=%h rnw=%b exp 1/20/3c/0", who, oa, ow, orr); end
    checks++; if (unst) begin errors++; $display("FAIL write_stable: mem bus changed during WAIT got 1 exp 0"); end
    checks++; if (odr !== m_d || err !== 1'b0) begin errors++; $display("FAIL write_rdata: got %h err=%b exp %h err=0", odr, err, m_d); end
    finish_access();
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL write_pulse: got %b exp 0", d_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rdv;
    @(negedge clk); rst = 1; @(negedge clk); rst = 0; model_reset();
    for (int i = 0; i < 4; i++) begin
      rdv = 8'($urandom);
      drive(1, 1, 8'h30, 8'h40, 8'h50, 1, 1 + (i % 2), rdv);
      model(1, 1, 1, ready_at, rdv);
      serve();
      checks++; if (tmo || who !== ed) begin errors++; $display("FAIL rr_order%0d: got d=%b tmo=%b exp d=%b", i, who, tmo, ed); end
      checks++; if (both) begin errors++; $display("FAIL rr_both%0d: got two dones exp one", i); end
      checks++; if (ofr !== m_f || odr !== m_d) begin errors++; $display("FAIL rr_data%0d: got f=%h d=%h exp f=%h d=%h", i, ofr, odr, m_f, m_d); end
    end
    finish_access();
  endtask

  task automatic test_timeout();
    drive(0, 1, 8'h00, 8'h81, 8'h00, 1, 255, 8'h12);
    model(0, 1, 1, 255, 8'h12);
    serve();
    checks++; if (tmo || lat != el) begin errors++; $display("FAIL timeout_latency: got %0d tmo=%b exp %0d", lat, tmo, el); end
    checks++; if (who !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL timeout_err: got d=%b err=%b exp 1/1", who, err); end
    checks++; if (odr !== 8'hFF) begin errors++; $display("FAIL timeout_rdata: got %h exp ff", odr); end
    finish_access();
    drive(1, 0, 8'h82, 8'h00, 8'h00, 1, 2, 8'h6B);
    model(1, 0, 1, 2, 8'h6B);
    serve();
    checks++; if (tmo || lat != el || err !== 1'b0 || ofr !== 8'h6B) begin errors++; $display("FAIL timeout_next: got lat=%0d err=%b rdata=%h exp %0d/0/6b", lat, err, ofr, el); end
    finish_access();
  endtask

  task automatic test_coincide();
    drive(0, 1, 8'h00, 8'h90, 8'h00, 1, TO, 8'h5A);
    model(0, 1, 1, TO, 8'h5A);
    serve();
    checks++; if (tmo || lat != el) begin errors++; $display("FAIL coincide_latency: got %0d exp %0d", lat, el); end
    checks++; if (err !== 1'b0 || odr !== 8'h5A) begin errors++; $display("FAIL coincide_data: got err=%b rdata=%h exp 0/5a", err, odr); end
    finish_access();
  endtask

  task automatic test_random();
    bit fr, dr, rnw;
    int rdy;
    logic [7:0] fa, da, dw, rdv;
    for (int i = 0; i < 24; i++) begin
      fr = 1'($urandom_range(0, 1));
      dr = fr ? 1'($urandom_range(0, 1)) : 1'b1;
      rnw = 1'($urandom_range(0, 1));
      rdy = $urandom_range(1, TO + 2);
      fa = 8'($urandom); da = 8'($urandom); dw = 8'($urandom); rdv = 8'($urandom);
      drive(fr, dr, fa, da, dw, rnw, rdy, rdv);
      model(fr, dr, rnw, rdy, rdv);
      serve();
      checks++; if (tmo || who !== ed || lat != el) begin errors++; $display("FAIL rand%0d_seq: got d=%b lat=%0d tmo=%b exp d=%b lat=%0d", i, who, lat, tmo, ed, el); end
      checks++; if (oa !== (ed ? da : fa) || orr !== (ed ? rnw : 1'b1) || (ed && !rnw && ow !== dw)) begin errors++; $display("FAIL rand%0d_bus: got addr=%h rnw=%b wdata=%h exp addr=%h rnw=%b wdata=%h", i, oa, orr, ow, ed ? da : fa, ed ? rnw : 1'b1, dw); end
      checks++; if (unst || both) begin errors++; $display("FAIL rand%0d_proto: got unstable=%b both=%b exp 0/0", i, unst, both); end
      checks++; if (err !== ee || ofr !== m_f || odr !== m_d) begin errors++; $display("FAIL rand%0d_data: got err=%b f=%h d=%h exp err=%b f=%h d=%h", i, err, ofr, odr, ee, m_f, m_d); end
      finish_access();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 8'h00, 8'h44, 8'h00, 1, 255, 8'h11);
    repeat (5) @(negedge clk);
    #2 rst = 1; #1;
    checks++; if (mem_enable !== 1'b0 || mem_rnw !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL midreset_bus: got en=%b rnw=%b addr=%h exp 0/1/00", mem_enable, mem_rnw, mem_addr); end
    checks++; if ({f_done, d_done, bus_err} !== 3'b000 || f_rdata !== 8'h00 || d_rdata !== 8'h00) begin errors++; $display("FAIL midreset_out: got flags=%b f=%h d=%h exp 000/00/00", {f_done, d_done, bus_err}, f_rdata, d_rdata); end
    model_reset();
    @(negedge clk);
    drive(1, 1, 8'h55, 8'h66, 8'h00, 1, 2, 8'h77);
    rst = 0;
    model(1, 1, 1, 2, 8'h77);
    serve();
    checks++; if (tmo || who !== 1'b0 || lat != el) begin errors++; $display("FAIL midreset_first: got d=%b lat=%0d exp d=0 lat=%0d", who, lat, el); end
    checks++; if (ofr !== 8'h77 || err !== 1'b0) begin errors++; $display("FAIL midreset_data: got %h err=%b exp 77/0", ofr, err); end
    f_req = 0;
    drive(0, 1, 8'h00, 8'h66, 8'h00, 1, 1, 8'h88);
    model(0, 1, 1, 1, 8'h88);
    serve();
    checks++; if (tmo || who !== 1'b1 || odr !== 8'h88) begin errors++; $display("FAIL midreset_second: got d=%b rdata=%h exp 1/88", who, odr); end
    finish_access();
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch();
    test_write();
    test_back_to_back();
    test_timeout();
    test_coincide();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the memory manager. It shares the single memory-manager port between instruction fetch (read-only) and the data path (read/write), driven by the control unit. It latches the winning request, runs the memory handshake, returns read data and pulses a per-requester done. A watchdog aborts accesses the memory never acknowledges.

Parameters:
DW, 8, data word width
AW, 8, address width
TIMEOUT, 15, max WAIT cycles before abort; 0 = watchdog disabled

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
f_req  in  1  fetch request, level, held until f_done
f_addr  in  AW  fetch address
f_rdata  out  DW  fetch read data, valid while f_done=1, held until next fetch done
f_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level, held until d_done
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rnw  in  1  1 = read, 0 = write
d_rdata  out  DW  data read data, valid while d_done=1, held until next data done
d_done  out  1  one-cycle data completion pulse
bus_err  out  1  high together with f_done/d_done when the access timed out
mem_addr  out  AW  address to memory manager
mem_wdata  out  DW  write word to memory manager
mem_rnw  out  1  1 = read, 0 = write
mem_enable  out  1  access strobe to memory manager
mem_rdata  in  DW  read word from memory manager
mem_ready  in  1  memory manager data-present / write-complete

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0, with one exception: mem_rnw=1. Last-served pointer = DATA, so fetch wins the first tie. Watchdog counter = 0. No done pulse is emitted for an aborted access.
- Arbitration happens in IDLE only:
  - One req high: grant it.
  - Both high: grant the requester not served last (round-robin).
  - On grant: latch addr, wdata and rnw into mem_* registers (fetch forces rnw=1), record the owner, update the pointer, go to ISSUE.
  - Requester inputs are don't-care after the grant edge.
- ISSUE (1 cycle): mem_enable=1; go to WAIT. mem_ready is ignored here.
- WAIT: mem_enable stays 1 and mem_addr/mem_wdata/mem_rnw stay stable. The watchdog increments every WAIT cycle.
  - mem_ready=1 sampled: capture mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged); go to DONE with bus_err=0.
  - Else, TIMEOUT!=0 and count==TIMEOUT-1: go to DONE with bus_err=1. The owner's rdata is set to all ones.
  - If mem_ready and the timeout coincide on the same edge, ready wins (bus_err=0).
- DONE (1 cycle):
  - Outputs: owner's done=1, bus_err as decided; mem_enable=0, watchdog cleared.
  - Next state is always IDLE. There is no direct re-grant from DONE, which gives the requester one cycle to drop req.
- Latency: req sampled at edge E0 → ISSUE after E0, WAIT after E1. With mem_ready high in the first WAIT cycle, done is high in the cycle after E2. Minimum is 3 cycles request-to-done, then 4 cycles per access including IDLE.
- mem_ready outside WAIT is ignored. The two done pulses are never high in the same cycle.
- Starvation bound: with both requesters continuously requesting, grants strictly alternate.

Test Plan:
- Reset then fetch: f_req=1, f_addr=8'h10, mem_ready=1 one cycle after mem_enable rises, mem_rdata=8'hA5 → mem_addr=8'h10, mem_rnw=1; f_done pulses 1 cycle; f_rdata=8'hA5; bus_err=0; exactly 3 cycles from req sample to done.
- Data write: d_req=1, d_rnw=0, d_addr=8'h20, d_wdata=8'h3C; mem_ready after 2 WAIT cycles → mem_wdata=8'h3C, mem_rnw=0 stable through WAIT; d_done single pulse; d_rdata unchanged.
- Simultaneous f_req and d_req held for 4 accesses right after reset → grant order F, D, F, D; never two dones in one cycle.
- Timeout: d_req read with mem_ready held 0, TIMEOUT=15 → after 15 WAIT cycles, d_done=1 and bus_err=1 in the same cycle; d_rdata=8'hFF; next access proceeds normally.
- Ready and timeout coincide on the last WAIT cycle → bus_err=0, data captured.
- Reset asserted mid-WAIT → all outputs immediately 0 except mem_rnw=1; no done pulse; after release, a pending fetch and data pair is served fetch first.
